// File: rtl/hdmi_tx_init_seq_if.sv
// ----------------------------------------------------------------------------
// hdmi_tx_init_seq_if
//   Byte-write request channel between the HDMI init sequencer and the I2C
//   byte-write engine.
//   master (sequencer): drives wr_valid/wr_dev/wr_reg/wr_data,
//                       receives wr_ready/wr_done/wr_nack.
//   slave  (engine)   : the mirror image.
//   wr_valid/wr_ready : request handshake, transfer on valid && ready.
//   wr_dev/reg/data   : 7-bit device address, register address, data byte.
//   wr_done/wr_nack   : one-cycle completion pulse, nack qualified by done.
// ----------------------------------------------------------------------------
interface hdmi_tx_init_seq_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_dev;
  logic [7:0] wr_reg;
  logic [7:0] wr_data;
  logic       wr_done;
  logic       wr_nack;

  modport master (
    output wr_valid, wr_dev, wr_reg, wr_data,
    input  wr_ready, wr_done, wr_nack
  );

  modport slave (
    input  wr_valid, wr_dev, wr_reg, wr_data,
    output wr_ready, wr_done, wr_nack
  );
endinterface

// File: rtl/hdmi_tx_init_seq.sv
// ----------------------------------------------------------------------------
// hdmi_tx_init_seq
//   Power-up and register-configuration sequencer for the HDMI transmitter and
//   LCD panel rails. On start it enables the panel supply, waits, streams a
//   fixed 10-entry register table to the I2C byte-write engine (retrying
//   NACKed writes), then enables the backlight. Every debounced falling edge
//   of hdmi_intn seen while idle-complete re-runs the table.
// Ports
//   clk, rst        : system clock, asynchronous active-high reset
//   start           : one-cycle request to run the full sequence
//   hdmi_intn       : transmitter interrupt, active low, asynchronous
//   wr              : write request channel (master side)
//   lcd_pwr_en      : panel supply enable
//   lcd_bl_en       : backlight enable
//   busy            : sequence in progress
//   init_ok         : table fully written
//   init_err        : an entry exhausted its retries
//   err_idx         : index of the failing entry
// ----------------------------------------------------------------------------
module hdmi_tx_init_seq #(
  parameter int unsigned PWR_DELAY_CYC = 5_000_000,
  parameter int unsigned BL_DELAY_CYC  = 10_000_000,
  parameter int unsigned DEBOUNCE_CYC  = 1000,
  parameter int unsigned RETRY_MAX     = 3,
  parameter int unsigned RETRY_GAP_CYC = 50_000,
  parameter logic [6:0]  DEV_ADDR      = 7'h39
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hdmi_intn,
  hdmi_tx_init_seq_if.master  wr,
  output logic                lcd_pwr_en,
  output logic                lcd_bl_en,
  output logic                busy,
  output logic                init_ok,
  output logic                init_err,
  output logic [3:0]          err_idx
);

  // A wait of N cycles ends when the counter (cleared on state entry) reaches
  // N-1; N=0 is treated like N=1 so every wait lasts at least one cycle.
  localparam logic [31:0] PWR_TC = (PWR_DELAY_CYC == 0) ? 32'd0 : 32'(PWR_DELAY_CYC - 1);
  localparam logic [31:0] BL_TC  = (BL_DELAY_CYC  == 0) ? 32'd0 : 32'(BL_DELAY_CYC  - 1);
  localparam logic [31:0] GAP_TC = (RETRY_GAP_CYC == 0) ? 32'd0 : 32'(RETRY_GAP_CYC - 1);
  localparam logic [31:0] DEB_TC = (DEBOUNCE_CYC  == 0) ? 32'd0 : 32'(DEBOUNCE_CYC  - 1);
  localparam logic [31:0] RETRY_LIM = 32'(RETRY_MAX);
  localparam logic [3:0]  LAST_IDX  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_RETRY_GAP,
    S_BL_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } tbl_entry_t;

  function automatic tbl_entry_t tbl_lookup(input logic [3:0] i);
    tbl_entry_t e;
    case (i)
      4'd0:    e = '{reg_addr: 8'h41, data: 8'h10};
      4'd1:    e = '{reg_addr: 8'h98, data: 8'h03};
      4'd2:    e = '{reg_addr: 8'h9A, data: 8'hE0};
      4'd3:    e = '{reg_addr: 8'h9C, data: 8'h30};
      4'd4:    e = '{reg_addr: 8'h9D, data: 8'h61};
      4'd5:    e = '{reg_addr: 8'hA2, data: 8'hA4};
      4'd6:    e = '{reg_addr: 8'hA3, data: 8'hA4};
      4'd7:    e = '{reg_addr: 8'hE0, data: 8'hD0};
      4'd8:    e = '{reg_addr: 8'h15, data: 8'h01};
      4'd9:    e = '{reg_addr: 8'h96, data: 8'hFF}; // clears pending interrupts
      default: e = '{reg_addr: 8'h00, data: 8'h00};
    endcase
    return e;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] retry_q, retry_d;
  logic        pwr_d, bl_d, ok_d, err_d;
  logic [3:0]  err_idx_d;

  // --------------------------------------------------------------------------
  // Interrupt path: 2-flop synchronizer, then a run-length debounce. The
  // debounced level returns high on the first high sample, so only a run of
  // DEBOUNCE_CYC consecutive lows produces a fall.
  // --------------------------------------------------------------------------
  logic [1:0]  intn_sync;
  logic [31:0] deb_cnt;
  logic        deb_lvl, deb_lvl_q;
  logic        irq_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intn_sync <= 2'b11;
      deb_cnt   <= '0;
      deb_lvl   <= 1'b1;
      deb_lvl_q <= 1'b1;
    end else begin
      intn_sync <= {intn_sync[0], hdmi_intn};
      deb_lvl_q <= deb_lvl;
      if (intn_sync[1]) begin
        deb_cnt <= '0;
        deb_lvl <= 1'b1;
      end else if (deb_cnt >= DEB_TC) begin
        deb_lvl <= 1'b0;                 // counter parks at terminal count
      end else begin
        deb_cnt <= deb_cnt + 32'd1;
      end
    end
  end

  // Edge, not level: a line held low re-inits once.
  assign irq_fall = deb_lvl_q & ~deb_lvl;

  // --------------------------------------------------------------------------
  // Shared wait counter for PWR_WAIT / RETRY_GAP / BL_WAIT; cleared whenever
  // the state changes so each wait starts from zero.
  // --------------------------------------------------------------------------
  logic [31:0] wait_cnt, wait_tc;
  logic        wait_hit;

  always_comb begin
    wait_tc = '0;
    case (state_q)
      S_PWR_WAIT:  wait_tc = PWR_TC;
      S_RETRY_GAP: wait_tc = GAP_TC;
      S_BL_WAIT:   wait_tc = BL_TC;
      default:     wait_tc = '0;
    endcase
  end

  assign wait_hit = (wait_cnt >= wait_tc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        wait_cnt <= '0;
    else if (state_d != state_q)    wait_cnt <= '0;
    else if (wait_cnt != '1)        wait_cnt <= wait_cnt + 32'd1;
  end

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      retry_q    <= '0;
      lcd_pwr_en <= 1'b0;
      lcd_bl_en  <= 1'b0;
      init_ok    <= 1'b0;
      init_err   <= 1'b0;
      err_idx    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      lcd_pwr_en <= pwr_d;
      lcd_bl_en  <= bl_d;
      init_ok    <= ok_d;
      init_err   <= err_d;
      err_idx    <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    pwr_d     = lcd_pwr_en;
    bl_d      = lcd_bl_en;
    ok_d      = init_ok;
    err_d     = init_err;
    err_idx_d = err_idx;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PWR_WAIT;
          pwr_d   = 1'b1;
        end
      end

      S_PWR_WAIT: begin
        if (wait_hit) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end
      end

      S_ISSUE: begin
        if (wr.wr_ready) state_d = S_WAIT_DONE;
      end

      // wr_done is only looked at here; pulses in other states are dropped.
      S_WAIT_DONE: begin
        if (wr.wr_done) begin
          if (!wr.wr_nack) begin
            retry_d = '0;
            if (idx_q != LAST_IDX) begin
              idx_d   = idx_q + 4'd1;
              state_d = S_ISSUE;
            end else if (!lcd_bl_en) begin
              state_d = S_BL_WAIT;
            end else begin
              // Hot-plug re-init: backlight already on, no second delay.
              state_d = S_DONE;
              ok_d    = 1'b1;
            end
          end else if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 32'd1;
            state_d = S_RETRY_GAP;
          end else begin
            err_idx_d = idx_q;
            err_d     = 1'b1;
            state_d   = S_ERR;
          end
        end
      end

      S_RETRY_GAP: begin
        if (wait_hit) state_d = S_ISSUE;
      end

      S_BL_WAIT: begin
        if (wait_hit) begin
          bl_d    = 1'b1;
          ok_d    = 1'b1;
          state_d = S_DONE;
        end
      end

      // start wins over a simultaneous interrupt: it rebuilds everything.
      S_DONE: begin
        if (start) begin
          ok_d    = 1'b0;
          err_d   = 1'b0;
          bl_d    = 1'b0;
          pwr_d   = 1'b1;
          state_d = S_PWR_WAIT;
        end else if (irq_fall) begin
          ok_d    = 1'b0;
          idx_d   = '0;
          retry_d = '0;
          state_d = S_ISSUE;
        end
      end

      S_ERR: begin
        if (start) begin
          ok_d    = 1'b0;
          err_d   = 1'b0;
          bl_d    = 1'b0;
          pwr_d   = 1'b1;
          state_d = S_PWR_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Register/data are gated by valid so every output idles at 0;
  // while valid is held they only depend on idx_q, which cannot change in
  // ISSUE, so they stay stable under backpressure.
  // --------------------------------------------------------------------------
  tbl_entry_t cur;
  assign cur = tbl_lookup(idx_q);

  assign wr.wr_valid = (state_q == S_ISSUE);
  assign wr.wr_dev   = DEV_ADDR;
  assign wr.wr_reg   = wr.wr_valid ? cur.reg_addr : 8'h00;
  assign wr.wr_data  = wr.wr_valid ? cur.data     : 8'h00;

  assign busy = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

endmodule

// File: tb/tb_hdmi_tx_init_seq.sv
// ----------------------------------------------------------------------------
// tb_hdmi_tx_init_seq
//   Directed bench for hdmi_tx_init_seq. Each scenario pushes the writes it
//   expects (register, data, cycles from previous done to valid) into a
//   queue; an independent monitor pops one entry per accepted request.
//   A small engine model answers every accepted write with wr_done three
//   cycles later, with configurable NACKs and backpressure.
// ----------------------------------------------------------------------------
module tb_hdmi_tx_init_seq;
  localparam int PWR  = 10;
  localparam int BL   = 20;
  localparam int DEB  = 4;
  localparam int GAP  = 5;
  localparam int RMAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hdmi_intn = 1'b1;
  logic       lcd_pwr_en, lcd_bl_en, busy, init_ok, init_err;
  logic [3:0] err_idx;

  hdmi_tx_init_seq_if bus ();

  hdmi_tx_init_seq #(
    .PWR_DELAY_CYC (PWR),
    .BL_DELAY_CYC  (BL),
    .DEBOUNCE_CYC  (DEB),
    .RETRY_MAX     (RMAX),
    .RETRY_GAP_CYC (GAP),
    .DEV_ADDR      (7'h39)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hdmi_intn  (hdmi_intn),
    .wr         (bus),
    .lcd_pwr_en (lcd_pwr_en),
    .lcd_bl_en  (lcd_bl_en),
    .busy       (busy),
    .init_ok    (init_ok),
    .init_err   (init_err),
    .err_idx    (err_idx)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r;
    logic [7:0] d;
    int         gap;   // -1: not checked
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] t_reg [10] = '{8'h41, 8'h98, 8'h9A, 8'h9C, 8'h9D, 8'hA2, 8'hA3, 8'hE0, 8'h15, 8'h96};
  logic [7:0] t_dat [10] = '{8'h10, 8'h03, 8'hE0, 8'h30, 8'h61, 8'hA4, 8'hA4, 8'hD0, 8'h01, 8'hFF};

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;
  int last_done_cyc = -100;
  int rise_cyc = 0;
  bit bl_fell = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
    end
  endtask

  // ---------------- engine model ----------------
  int         pend = 0;
  logic [7:0] pend_reg = 8'h00;
  int         hold = 0;
  bit         bp_arm = 0;
  logic [7:0] nack_reg = 8'h00;
  int         nack_left = 0;    // -1: NACK forever

  initial begin : engine
    bit         acc;
    logic [7:0] acc_reg;
    bus.wr_ready = 1'b1;
    bus.wr_done  = 1'b0;
    bus.wr_nack  = 1'b0;
    forever begin
      @(negedge clk);
      acc     = bus.wr_valid && bus.wr_ready;
      acc_reg = bus.wr_reg;
      @(posedge clk);
      #1;
      bus.wr_done = 1'b0;
      bus.wr_nack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.wr_done = 1'b1;
          if (pend_reg == nack_reg && nack_left != 0) begin
            bus.wr_nack = 1'b1;
            if (nack_left > 0) nack_left--;
          end
        end
      end
      if (acc) begin
        pend     = 2;
        pend_reg = acc_reg;
      end
      if (bp_arm && bus.wr_valid) begin
        bp_arm = 0;
        hold   = 7;
      end
      if (hold > 0) begin
        bus.wr_ready = 1'b0;
        hold--;
      end else begin
        bus.wr_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic pv;
    logic pbl;
    exp_t e;
    pv  = 1'b0;
    pbl = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_valid && !pv) rise_cyc = cyc;
      pv = bus.wr_valid;
      if (pbl && !lcd_bl_en && !rst) bl_fell = 1;
      pbl = lcd_bl_en;
      if (bus.wr_done) last_done_cyc = cyc;
      if (bus.wr_valid && bus.wr_ready) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got reg 0x%02h data 0x%02h, want no write", bus.wr_reg, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_reg", 32'(bus.wr_reg), 32'(e.r));
          chk("wr_data", 32'(bus.wr_data), 32'(e.d));
          chk("wr_dev", 32'(bus.wr_dev), 32'h39);
          if (e.gap >= 0) chk("issue_gap", 32'(rise_cyc - last_done_cyc), 32'(e.gap));
        end
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic push_one(input int i, input int gap);
    exp_t e;
    e.r = t_reg[i];
    e.d = t_dat[i];
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Entries from..to; the first with first_gap, the rest back-to-back.
  task automatic push_run(input int from, input int to, input int first_gap);
    for (int i = from; i <= to; i++) push_one(i, (i == from) ? first_gap : 1);
  endtask

  // Returns #1 after the edge that samples start; c is cyc when start rose.
  task automatic pulse_start(output int c);
    @(posedge clk);
    #1;
    start = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // which: 0 init_ok, 1 wr_valid, 2 init_err, 3 busy
  task automatic wait_for(input string nm, input int which, input int bound, output int at);
    bit hit;
    hit = 0;
    at  = -1;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = init_ok;
        1:       hit = bus.wr_valid;
        2:       hit = init_err;
        default: hit = busy;
      endcase
      if (hit) at = cyc;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: got no event in %0d cycles, want event", nm, bound);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"},  32'(bus.wr_valid), 0);
    chk({nm, "_reg"},    32'(bus.wr_reg), 0);
    chk({nm, "_data"},   32'(bus.wr_data), 0);
    chk({nm, "_pwr"},    32'(lcd_pwr_en), 0);
    chk({nm, "_bl"},     32'(lcd_bl_en), 0);
    chk({nm, "_busy"},   32'(busy), 0);
    chk({nm, "_ok"},     32'(init_ok), 0);
    chk({nm, "_err"},    32'(init_err), 0);
    chk({nm, "_erridx"}, 32'(err_idx), 0);
    chk({nm, "_dev"},    32'(bus.wr_dev), 32'h39);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int c, at, base;
    bit seen_valid;

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Nominal init
    push_run(0, 9, -1);
    base = n_wr;
    pulse_start(c);
    chk("nom_pwr_after_start", 32'(lcd_pwr_en), 1);
    chk("nom_busy", 32'(busy), 1);
    wait_for("nom_first_valid", 1, 100, at);
    chk("nom_pwr_delay", 32'(at - c), 32'(PWR + 1));
    wait_for("nom_init_ok", 0, 300, at);
    chk("nom_bl_delay", 32'(at - last_done_cyc), 32'(BL + 1));
    chk("nom_bl_en", 32'(lcd_bl_en), 1);
    chk("nom_busy_end", 32'(busy), 0);
    chk("nom_writes", 32'(n_wr - base), 10);
    chk("nom_queue_empty", 32'(exp_q.size()), 0);

    // Hot-plug glitch: 3 low cycles is below the debounce length
    base = n_wr;
    @(posedge clk);
    #1;
    hdmi_intn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    hdmi_intn = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_writes", 32'(n_wr - base), 0);
    chk("glitch_ok", 32'(init_ok), 1);

    // Hot-plug: 10 low cycles -> one re-init, backlight kept
    push_run(0, 9, -1);
    base = n_wr;
    bl_fell = 0;
    @(posedge clk);
    #1;
    hdmi_intn = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    hdmi_intn = 1'b1;
    wait_for("hp_busy", 3, 40, at);
    wait_for("hp_init_ok", 0, 300, at);
    repeat (20) @(negedge clk);
    chk("hp_writes", 32'(n_wr - base), 10);
    chk("hp_bl_kept", 32'(bl_fell), 0);
    chk("hp_ok", 32'(init_ok), 1);

    // Hot-plug: line held low well past the re-init fires only once
    push_run(0, 9, -1);
    base = n_wr;
    @(posedge clk);
    #1;
    hdmi_intn = 1'b0;
    wait_for("held_busy", 3, 40, at);
    wait_for("held_init_ok", 0, 300, at);
    repeat (40) @(negedge clk);
    chk("held_writes", 32'(n_wr - base), 10);
    chk("held_bl", 32'(lcd_bl_en), 1);
    @(posedge clk);
    #1;
    hdmi_intn = 1'b1;
    repeat (10) @(negedge clk);

    // NACK retry: entry 3 NACKed twice
    nack_reg  = 8'h9C;
    nack_left = 2;
    push_run(0, 3, -1);
    push_one(3, GAP + 1);
    push_one(3, GAP + 1);
    push_run(4, 9, 1);
    base = n_wr;
    pulse_start(c);
    chk("retry_bl_cleared", 32'(lcd_bl_en), 0);
    chk("retry_ok_cleared", 32'(init_ok), 0);
    chk("retry_pwr", 32'(lcd_pwr_en), 1);
    wait_for("retry_init_ok", 0, 400, at);
    chk("retry_writes", 32'(n_wr - base), 12);
    chk("retry_err", 32'(init_err), 0);

    // Retry exhaustion on entry 5
    nack_reg  = 8'hA2;
    nack_left = -1;
    push_run(0, 5, -1);
    for (int i = 0; i < RMAX; i++) push_one(5, GAP + 1);
    base = n_wr;
    pulse_start(c);
    wait_for("exh_init_err", 2, 400, at);
    repeat (5) @(negedge clk);
    chk("exh_writes", 32'(n_wr - base), 9);
    chk("exh_err_idx", 32'(err_idx), 5);
    chk("exh_busy", 32'(busy), 0);
    chk("exh_bl", 32'(lcd_bl_en), 0);
    chk("exh_ok", 32'(init_ok), 0);
    chk("exh_pwr", 32'(lcd_pwr_en), 1);
    chk("exh_queue_empty", 32'(exp_q.size()), 0);

    // start from ERR reruns from PWR_WAIT
    nack_left = 0;
    push_run(0, 9, -1);
    base = n_wr;
    pulse_start(c);
    chk("err_restart_err_clr", 32'(init_err), 0);
    chk("err_restart_busy", 32'(busy), 1);
    wait_for("err_restart_valid", 1, 100, at);
    chk("err_restart_pwr_delay", 32'(at - c), 32'(PWR + 1));
    wait_for("err_restart_ok", 0, 300, at);
    chk("err_restart_writes", 32'(n_wr - base), 10);

    // Backpressure on entry 0, with a stray start mid-sequence
    bp_arm = 1;
    push_run(0, 9, -1);
    base = n_wr;
    pulse_start(c);
    wait_for("bp_valid", 1, 100, at);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid_held", 32'(bus.wr_valid), 1);
      chk("bp_reg_stable", 32'(bus.wr_reg), 32'h41);
      chk("bp_data_stable", 32'(bus.wr_data), 32'h10);
      start = (i == 3);
    end
    start = 1'b0;
    wait_for("bp_init_ok", 0, 400, at);
    chk("bp_writes", 32'(n_wr - base), 10);

    // Async reset while waiting for entry 6's done
    push_run(0, 6, -1);
    base = n_wr;
    pulse_start(c);
    for (int i = 0; i < 300 && n_wr != base + 7; i++) @(negedge clk);
    chk("rst_reached_entry6", 32'(n_wr - base), 7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.wr_valid) seen_valid = 1;
    end
    chk("midrst_no_valid", 32'(seen_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ok", 32'(init_ok), 0);
    chk("midrst_pwr", 32'(lcd_pwr_en), 0);
    chk("midrst_writes", 32'(n_wr - base), 7);

    // Still IDLE: a fresh start follows the normal power-up timing
    push_run(0, 9, -1);
    base = n_wr;
    pulse_start(c);
    wait_for("post_rst_valid", 1, 100, at);
    chk("post_rst_pwr_delay", 32'(at - c), 32'(PWR + 1));
    wait_for("post_rst_ok", 0, 300, at);
    chk("post_rst_writes", 32'(n_wr - base), 10);
    chk("post_rst_queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
